seq_wide_adder: RTL
===================

SEQ_WIDE_ADDER -- requirements
Module: seq_wide_adder

Interface
REQ-001 SHALL have parameter TOTAL_WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 16, width of the single shared adder.
REQ-003 SHALL have parameter ADDER_TYPE (string), default "BEHAVIORAL_ADDER", forwarded to the adder instance.
REQ-004 SHALL have ports: clk  in  1  sole clock; rising edge.
REQ-005 SHALL have: rst_n  in  1  reset; synchronous, active-low.
REQ-006 SHALL have: in_valid  in  1; in_ready  out  1  operand handshake.
REQ-007 SHALL have: a, b  in  TOTAL_WIDTH  operands; cin  in  1  carry-in.
REQ-008 SHALL have: chain  in  1  1 = one TOTAL_WIDTH add; 0 = independent CHUNK_WIDTH element adds.
REQ-009 SHALL have: out_valid  out  1; out_ready  in  1  result handshake.
REQ-010 SHALL have: sum  out  TOTAL_WIDTH; cout  out  1; overflow  out  1; chunk_cout  out  NUM_CHUNKS  per-chunk carry-out.
REQ-011 SHALL have: busy  out  1  high whenever state is not IDLE.

Function
REQ-012 NUM_CHUNKS = TOTAL_WIDTH/CHUNK_WIDTH; elaboration SHALL $fatal if not an exact integer or if NUM_CHUNKS < 2.
REQ-013 FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-014 IDLE: on in_valid, latch a, b, cin, chain (and sub), clear chunk index and sum, set carry register = cin, go to RUN.
REQ-015 RUN: each cycle add chunk[idx] of a and b with the carry register; write sum chunk idx and chunk_cout[idx]; increment idx; leave for DONE after idx = NUM_CHUNKS-1.
REQ-016 Next carry: chain=1 -> adder cout; chain=0 -> latched cin (every element uses the same carry-in).
REQ-017 On the final chunk, cout <= adder cout; overflow <= adder prev_cout XOR adder cout.
REQ-018 Latency: handshake at edge T, RUN for edges T+1..T+NUM_CHUNKS, out_valid high from cycle after edge T+NUM_CHUNKS (5 cycles at default).
REQ-019 DONE: out_valid = 1; sum, cout, overflow, chunk_cout held stable until out_ready = 1, then go to IDLE.
REQ-020 in_valid and input changes while not in IDLE SHALL be ignored; no operand is accepted in the same cycle as the DONE to IDLE transition.

Reset
REQ-021 rst_n = 0 at any edge, including mid-RUN or DONE, SHALL force IDLE and discard the operation.
REQ-022 Reset values: sum = 0, cout = 0, overflow = 0, chunk_cout = 0, out_valid = 0, busy = 0; in_ready = 1 in the first cycle after reset.

Configuration
REQ-023 Macro SEQ_WIDE_ADDER_SUB_EN, when defined, SHALL add input port sub (1 bit), latched with the operands.
REQ-024 With sub = 1: every b chunk is inverted, and the initial carry (chain=1) or every element carry (chain=0) is forced to 1, ignoring cin.
REQ-025 Without the macro: no sub port; behaviour is add-only.

Structure
REQ-026 Package seq_wide_adder_pkg SHALL hold the state enum typedef and the default width constants.
REQ-027 Exactly one adder_nbit instance of CHUNK_WIDTH SHALL be instantiated; its operands are muxed by chunk index.

Verification (TOTAL 64, CHUNK 16)
REQ-028 chain=1, a=0x0000_0000_0000_FFFF, b=1, cin=0 -> sum=0x0000_0000_0001_0000, chunk_cout=4'b0001, cout=0, out_valid 5 cycles after accept.
REQ-029 chain=1, a=all ones, b=1 -> sum=0, cout=1, overflow=0.
REQ-030 chain=0, a=0xFFFF_0001_7FFF_0000, b=0x0001_0001_0001_0000, cin=0 -> sum=0x0000_0002_8000_0000, chunk_cout=4'b1000, cout=1, overflow=0.
REQ-031 out_ready low for 10 cycles in DONE, new in_valid pulsed -> outputs stable, in_ready=0, new operands not accepted.
REQ-032 rst_n low for one edge at second RUN cycle -> next cycle IDLE, in_ready=1, out_valid=0, sum=0.
REQ-033 SUB_EN: chain=1, sub=1, a=5, b=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0.

Source files
------------

// File: rtl/seq_wide_adder_pkg.sv
// seq_wide_adder_pkg
//   Shared definitions for the sequential wide adder:
//   - state_e           : controller FSM states
//   - DEF_TOTAL_WIDTH   : default operand/result width
//   - DEF_CHUNK_WIDTH   : default width of the shared chunk adder
package seq_wide_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_TOTAL_WIDTH = 64;
    localparam int DEF_CHUNK_WIDTH = 16;

endpackage

// File: rtl/seq_wide_adder_adder_nbit.sv
// adder_nbit
//   WIDTH-bit adder with carry-in. It also exposes the carry into the MSB
//   (prev_cout_o), so the caller can form signed overflow.
//   ADDER_TYPE picks the implementation. "RIPPLE_ADDER" gives an explicit
//   ripple chain. Any other value gives the behavioural '+'.
// Ports:
//   a_i, b_i     in  WIDTH  operands
//   cin_i        in  1      carry-in
//   sum_o        out WIDTH  sum
//   cout_o       out 1      carry out of the MSB
//   prev_cout_o  out 1      carry into the MSB
module adder_nbit #(
    parameter int    WIDTH      = 16,
    parameter string ADDER_TYPE = "BEHAVIORAL_ADDER"
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             prev_cout_o
);

    if (ADDER_TYPE == "RIPPLE_ADDER") begin : g_ripple
        logic [WIDTH:0] c;
        always_comb begin
            c    = '0;
            c[0] = cin_i;
            for (int i = 0; i < WIDTH; i++) begin
                c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
            end
        end
        assign sum_o       = a_i ^ b_i ^ c[WIDTH-1:0];
        assign cout_o      = c[WIDTH];
        assign prev_cout_o = c[WIDTH-1];
    end else begin : g_behav
        logic [WIDTH:0] full;
        assign full        = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
        assign sum_o       = full[WIDTH-1:0];
        assign cout_o      = full[WIDTH];
        // The sum bit is a^b^carry_in, so the carry into the MSB can be recovered from it.
        assign prev_cout_o = full[WIDTH-1] ^ a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end

endmodule

// File: rtl/seq_wide_adder.sv
// seq_wide_adder
//   A TOTAL_WIDTH add built from one shared CHUNK_WIDTH adder. The adder
//   processes one chunk per cycle.
//   chain=1 : the carry ripples between chunks, giving one wide add.
//   chain=0 : each chunk is an independent element add. Every element uses
//             the latched carry-in.
//   Optional macro SEQ_WIDE_ADDER_SUB_EN adds input 'sub'. When sub=1, b is
//   inverted and the carry-in is forced to 1, so the block computes a - b.
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   a, b, cin, chain     operands, carry-in, mode
//   sub                  subtract (only with SEQ_WIDE_ADDER_SUB_EN)
//   out_valid/out_ready  result handshake
//   sum, cout, overflow  result, final carry, signed overflow of the top chunk
//   chunk_cout           per-chunk carry-out
//   busy                 high whenever the FSM is not in IDLE
module seq_wide_adder
    import seq_wide_adder_pkg::*;
#(
    parameter int    TOTAL_WIDTH = DEF_TOTAL_WIDTH,
    parameter int    CHUNK_WIDTH = DEF_CHUNK_WIDTH,
    parameter string ADDER_TYPE  = "BEHAVIORAL_ADDER",
    localparam int   NUM_CHUNKS  = TOTAL_WIDTH / CHUNK_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] a,
    input  logic [TOTAL_WIDTH-1:0] b,
    input  logic                   cin,
    input  logic                   chain,
`ifdef SEQ_WIDE_ADDER_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] sum,
    output logic                   cout,
    output logic                   overflow,
    output logic [NUM_CHUNKS-1:0]  chunk_cout,
    output logic                   busy
);

    if ((TOTAL_WIDTH % CHUNK_WIDTH) != 0 || NUM_CHUNKS < 2) begin : g_bad_cfg
        $fatal(1, "seq_wide_adder: TOTAL_WIDTH must be a multiple (>=2x) of CHUNK_WIDTH");
    end

    localparam int                IDX_W    = $clog2(NUM_CHUNKS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0] chunks_t;

    // Subtraction is folded in at accept time. b is stored already
    // inverted and the carry-in is stored already forced to 1.
    logic in_sub;
`ifdef SEQ_WIDE_ADDER_SUB_EN
    assign in_sub = sub;
`else
    assign in_sub = 1'b0;
`endif

    logic [TOTAL_WIDTH-1:0] b_in;
    logic                   cin_in;
    assign b_in   = b ^ {TOTAL_WIDTH{in_sub}};
    assign cin_in = in_sub | cin;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    chunks_t            a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               cin_q, cin_d, chain_q, chain_d, carry_q, carry_d;
    logic               cout_q, cout_d, ovf_q, ovf_d;
    logic [NUM_CHUNKS-1:0] cc_q, cc_d;

    logic [CHUNK_WIDTH-1:0] add_sum;
    logic                   add_cout, add_prev;

    adder_nbit #(
        .WIDTH      (CHUNK_WIDTH),
        .ADDER_TYPE (ADDER_TYPE)
    ) u_adder (
        .a_i         (a_q[idx_q]),
        .b_i         (b_q[idx_q]),
        .cin_i       (carry_q),
        .sum_o       (add_sum),
        .cout_o      (add_cout),
        .prev_cout_o (add_prev)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cin_q   <= 1'b0;
            chain_q <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cin_q   <= cin_d;
            chain_q <= chain_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cc_q    <= cc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cin_d   = cin_q;
        chain_d = chain_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cc_d    = cc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_in;
                    cin_d   = cin_in;
                    chain_d = chain;
                    carry_d = cin_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    cc_d    = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q] = add_sum;
                cc_d[idx_q]  = add_cout;
                // In element mode every chunk restarts from the latched carry-in.
                carry_d      = chain_q ? add_cout : cin_q;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    ovf_d   = add_prev ^ add_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign sum        = sum_q;
    assign cout       = cout_q;
    assign overflow   = ovf_q;
    assign chunk_cout = cc_q;

endmodule
